// File: rtl/event_blinker_pkg.sv
// Shared definitions for the event blinker and other indicator blocks:
// FSM state encodings and default blink timing constants.
package event_blinker_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } blink_state_e;

   localparam int unsigned DEF_TMR_W       = 24;
   localparam logic [23:0] DEF_ON_TICKS    = 24'd6250000;
   localparam logic [23:0] DEF_OFF_TICKS   = 24'd6250000;
   localparam int unsigned DEF_MAX_PENDING = 7;

endpackage

// File: rtl/event_blinker_timer.sv
// Loadable down-counter with zero detect; holds at zero until reloaded.
module blink_timer
   import event_blinker_pkg::*;
#(
   parameter int unsigned TMR_W = DEF_TMR_W
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_value,
   output logic             expired
);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_value;
      else if (cnt_q != '0)
         cnt_d = cnt_q - TMR_W'(1);
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/event_blinker.sv
// Turns single-cycle event pulses into ON/OFF blinks, queueing events that
// arrive mid-blink in a saturating pending counter.
module event_blinker
   import event_blinker_pkg::*;
#(
   parameter int unsigned      TMR_W       = DEF_TMR_W,
   parameter logic [TMR_W-1:0] ON_TICKS    = TMR_W'(DEF_ON_TICKS),
   parameter logic [TMR_W-1:0] OFF_TICKS   = TMR_W'(DEF_OFF_TICKS),
   parameter int unsigned      MAX_PENDING = DEF_MAX_PENDING,
   localparam int unsigned     PEND_W      = $clog2(MAX_PENDING + 1)
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              in,
   output logic              out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              dropped
);

   localparam logic [TMR_W-1:0]  ON_LOAD  = ON_TICKS - TMR_W'(1);
   localparam logic [TMR_W-1:0]  OFF_LOAD = OFF_TICKS - TMR_W'(1);
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

   blink_state_e      state_q, state_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              out_q, out_d;
   logic              busy_q, busy_d;
   logic              dropped_q, dropped_d;

   logic              start;
   logic              inc, dec;
   logic              tmr_load, tmr_expired;
   logic [TMR_W-1:0]  tmr_load_val;

   blink_timer #(.TMR_W(TMR_W)) u_timer (
      .CLK        (CLK),
      .RST_n      (RST_n),
      .load       (tmr_load),
      .load_value (tmr_load_val),
      .expired    (tmr_expired)
   );

   // Next state; every entry into ON or OFF reloads the timer.
   always_comb begin
      state_d      = state_q;
      start        = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = ON_LOAD;
      unique case (state_q)
         IDLE: start = in || (pend_q != '0);
         ON: begin
            if (tmr_expired) begin
               state_d      = OFF;
               tmr_load     = 1'b1;
               tmr_load_val = OFF_LOAD;
            end
         end
         OFF: begin
            if (tmr_expired) begin
               if (in || (pend_q != '0))
                  start = 1'b1;
               else
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (start) begin
         state_d      = ON;
         tmr_load     = 1'b1;
         tmr_load_val = ON_LOAD;
      end
   end

   // A fresh pulse starting a blink bypasses the queue; otherwise a start
   // drains one queued event, which is nonzero whenever start fires without in.
   always_comb begin
      inc       = in && !start;
      dec       = start && !in;
      pend_d    = pend_q;
      dropped_d = 1'b0;
      if (inc && !dec) begin
         if (pend_q == PEND_MAX)
            dropped_d = 1'b1;
         else
            pend_d = pend_q + PEND_W'(1);
      end else if (dec && !inc) begin
         pend_d = pend_q - PEND_W'(1);
      end
   end

   always_comb begin
      out_d  = (state_d == ON);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         pend_q    <= '0;
         out_q     <= 1'b0;
         busy_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         out_q     <= out_d;
         busy_q    <= busy_d;
         dropped_q <= dropped_d;
      end
   end

   assign out     = out_q;
   assign busy    = busy_q;
   assign pending = pend_q;
   assign dropped = dropped_q;

endmodule

// File: tb/tb_event_blinker.sv
// Bench for event_blinker with ON_TICKS=4, OFF_TICKS=3, MAX_PENDING=3:
// table of pulse scenarios with spec-derived expectations, plus a reset sequence.
module tb_event_blinker;

   logic       CLK;
   logic       RST_n;
   logic       in;
   logic       out;
   logic       busy;
   logic [1:0] pending;
   logic       dropped;

   int n_pass = 0;
   int n_tot  = 0;

   event_blinker #(
      .TMR_W       (24),
      .ON_TICKS    (24'd4),
      .OFF_TICKS   (24'd3),
      .MAX_PENDING (3)
   ) dut (
      .CLK     (CLK),
      .RST_n   (RST_n),
      .in      (in),
      .out     (out),
      .busy    (busy),
      .pending (pending),
      .dropped (dropped)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int          ncyc;
      logic [63:0] in_m;
      logic [63:0] out_m;
      logic [63:0] busy_m;
      logic [63:0] drop_m;
      int          pend [64];
      int          n_blinks;
      int          n_drops;
   } scen_t;

   typedef struct {
      int o;
      int b;
      int d;
      int p;
   } exp_t;

   scen_t tbl [5];
   string names [5];
   exp_t  sbq [$];

   function automatic logic [63:0] rng(input int lo, input int hi);
      logic [63:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic set_pend(input int s, input int lo, input int hi, input int v);
      for (int c = lo; c <= hi; c++) tbl[s].pend[c] = v;
   endtask

   task automatic chk(input string nm, input int act, input int expv);
      n_tot++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
   endtask

   // Cycle 0 is the cycle in which reset is released; in for cycle c is
   // driven after the edge opening cycle c, its effect expected in cycle c+1.
   task automatic run(input int s, input int ncyc, input bit totals);
      exp_t e, x;
      int   blinks, drops;
      logic prev_o;
      in    = 1'b0;
      RST_n = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST_n = 1'b1;
      sbq.delete();
      x.o = 0; x.b = 0; x.d = 0; x.p = 0;
      sbq.push_back(x);
      blinks = 0;
      drops  = 0;
      prev_o = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         if (c > 0) begin
            @(posedge CLK);
            #1;
         end
         e = sbq.pop_front();
         chk($sformatf("%s c%0d out", names[s], c), int'(out), e.o);
         chk($sformatf("%s c%0d busy", names[s], c), int'(busy), e.b);
         chk($sformatf("%s c%0d pending", names[s], c), int'(pending), e.p);
         chk($sformatf("%s c%0d dropped", names[s], c), int'(dropped), e.d);
         if (out && !prev_o) blinks++;
         prev_o = out;
         if (dropped) drops++;
         in  = tbl[s].in_m[c];
         x.o = int'(tbl[s].out_m[c+1]);
         x.b = int'(tbl[s].busy_m[c+1]);
         x.d = int'(tbl[s].drop_m[c+1]);
         x.p = tbl[s].pend[c+1];
         sbq.push_back(x);
      end
      in = 1'b0;
      if (totals) begin
         chk($sformatf("%s blinks", names[s]), blinks, tbl[s].n_blinks);
         chk($sformatf("%s drops", names[s]), drops, tbl[s].n_drops);
      end
   endtask

   initial begin
      in    = 1'b0;
      RST_n = 1'b0;

      for (int s = 0; s < 5; s++) begin
         tbl[s].in_m   = '0;
         tbl[s].drop_m = '0;
         tbl[s].n_drops = 0;
         for (int c = 0; c < 64; c++) tbl[s].pend[c] = 0;
      end

      names[0] = "single";
      tbl[0].ncyc     = 25;
      tbl[0].in_m     = rng(10, 10);
      tbl[0].out_m    = rng(11, 14);
      tbl[0].busy_m   = rng(11, 17);
      tbl[0].n_blinks = 1;

      names[1] = "three";
      tbl[1].ncyc     = 40;
      tbl[1].in_m     = rng(10, 10) | rng(12, 13);
      tbl[1].out_m    = rng(11, 14) | rng(18, 21) | rng(25, 28);
      tbl[1].busy_m   = rng(11, 31);
      tbl[1].n_blinks = 3;
      set_pend(1, 13, 13, 1);
      set_pend(1, 14, 17, 2);
      set_pend(1, 18, 24, 1);

      names[2] = "saturate";
      tbl[2].ncyc     = 45;
      tbl[2].in_m     = rng(10, 10) | rng(12, 16);
      tbl[2].out_m    = rng(11, 14) | rng(18, 21) | rng(25, 28) | rng(32, 35);
      tbl[2].busy_m   = rng(11, 38);
      tbl[2].drop_m   = rng(16, 17);
      tbl[2].n_blinks = 4;
      tbl[2].n_drops  = 2;
      set_pend(2, 13, 13, 1);
      set_pend(2, 14, 14, 2);
      set_pend(2, 15, 17, 3);
      set_pend(2, 18, 24, 2);
      set_pend(2, 25, 31, 1);

      names[3] = "lastoff";
      tbl[3].ncyc     = 30;
      tbl[3].in_m     = rng(10, 10) | rng(17, 17);
      tbl[3].out_m    = rng(11, 14) | rng(18, 21);
      tbl[3].busy_m   = rng(11, 24);
      tbl[3].n_blinks = 2;

      // Pulse on the OFF expiry cycle while two events are queued: the pulse
      // starts the blink directly, so pending holds at 2.
      names[4] = "samecyc";
      tbl[4].ncyc     = 45;
      tbl[4].in_m     = rng(10, 10) | rng(12, 13) | rng(17, 17);
      tbl[4].out_m    = rng(11, 14) | rng(18, 21) | rng(25, 28) | rng(32, 35);
      tbl[4].busy_m   = rng(11, 38);
      tbl[4].n_blinks = 4;
      set_pend(4, 13, 13, 1);
      set_pend(4, 14, 24, 2);
      set_pend(4, 25, 31, 1);

      for (int s = 0; s < 5; s++) run(s, tbl[s].ncyc, 1'b1);

      // Reset mid-ON with pending=2 must clear outputs without a clock edge.
      run(1, 15, 1'b0);
      #3;
      RST_n = 1'b0;
      #1;
      chk("rst async out", int'(out), 0);
      chk("rst async busy", int'(busy), 0);
      chk("rst async pending", int'(pending), 0);
      chk("rst async dropped", int'(dropped), 0);
      @(posedge CLK);
      #1;
      chk("rst held out", int'(out), 0);
      chk("rst held busy", int'(busy), 0);
      RST_n = 1'b1;
      in    = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge CLK);
         #1;
         in = 1'b0;
         chk($sformatf("post-rst k%0d out", k), int'(out), int'(k <= 4));
         chk($sformatf("post-rst k%0d busy", k), int'(busy), int'(k <= 7));
         chk($sformatf("post-rst k%0d pending", k), int'(pending), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/event_blinker.md
Name: event_blinker

Overview:
- Converts single-cycle event pulses (e.g. from the key debouncer or mode-change logic) into human-visible timed blinks on an LED or on-screen indicator.
- Each accepted pulse produces exactly one ON period followed by one OFF gap.
- Pulses that arrive while a blink is in progress are queued in a saturating pending counter and replayed back-to-back.
- Sits between event sources and board LEDs / HDMI overlay flag inputs.

Parameters:
- ON_TICKS, 24'd6250000, length of the ON period in CLK cycles; must be >= 1.
- OFF_TICKS, 24'd6250000, length of the OFF gap in CLK cycles; must be >= 1.
- TMR_W, 24, width of the internal tick timer; must hold max(ON_TICKS, OFF_TICKS)-1.
- MAX_PENDING, 7, maximum queued events; must be >= 1. PEND_W = clog2(MAX_PENDING+1).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_n  input  1  asynchronous, active-low reset.
- in  input  1  event pulse; each cycle high counts as one event.
- out  output  1  blink output; high during the ON period.
- busy  output  1  high in the ON and OFF states.
- pending  output  PEND_W  number of queued events not yet started.
- dropped  output  1  one-cycle pulse when an event is discarded at saturation.

Behaviour:
- Reset: asynchronous on RST_n low, with immediate effect, including mid-blink.
  - State goes to IDLE; timer, pending, out, busy and dropped all go to 0.
  - Operation resumes on the first rising edge after RST_n goes high.
- States: IDLE, ON, OFF. out is 1 only in ON; busy is 1 in ON and OFF. Both are registered, decoded from state.
- Timer: down-counter, loaded with TICKS-1 on entry to ON or OFF; expiry when it is 0 in that state.
  - ON therefore lasts exactly ON_TICKS cycles and OFF lasts exactly OFF_TICKS cycles.
- IDLE: if in=1 or pending>0, go to ON at the next edge and load ON_TICKS-1.
  - An event from in takes priority. It bypasses the queue and pending does not change.
  - Otherwise the start consumes one queued event: pending decrements by 1.
- Latency: in high in cycle k while IDLE with pending=0 gives out=1 from edge k+1.
- ON: on expiry, go to OFF and load OFF_TICKS-1. Otherwise decrement the timer.
- OFF: on expiry, go to ON if pending>0 or in=1, with the same consume rule as IDLE; otherwise go to IDLE.
  - There is no idle cycle between the last OFF cycle and the next ON cycle.
- Pending update rule, evaluated every edge:
  - inc = in=1 and the event is not consumed directly by a start.
  - dec = a start consumes a queued event.
  - inc and dec together: pending is unchanged.
  - inc at pending=MAX_PENDING without dec: pending stays; dropped=1 for one cycle (registered).
  - dec never underflows.
- in held high for N cycles counts as N events, so sources must deliver single-cycle pulses.
- In ON, in=1 on the expiry cycle queues normally; ON is never retriggered or extended.
- With ON_TICKS=1 or OFF_TICKS=1, the state lasts exactly one cycle.
- Arithmetic: all unsigned. The timer never wraps because it is reloaded on every state entry.

Decomposition:
- Shared package/header holds the state encodings IDLE=2'd0, ON=2'd1, OFF=2'd2, and the default tick constants used by other indicator blocks.
- One natural sub-module: blink_timer.
  - Ports: CLK, RST_n, load, load_value[TMR_W], expired.
  - Function: loadable down-counter with zero detect.
- The FSM and the pending counter stay in event_blinker.

Test Plan (ON_TICKS=4, OFF_TICKS=3, MAX_PENDING=3):
- Single pulse in cycle 10 from IDLE -> out=1 for cycles 11-14, out=0 and busy=1 for 15-17, busy=0 from 18; pending stays 0 throughout.
- Pulses in cycles 10, 12, 13 -> pending goes 1 then 2. Three ON periods start at cycles 11, 18 and 25, each 4 cycles, with 3-cycle gaps. busy=0 from cycle 32; pending=0 at the end.
- Five pulses in cycles 12-16 while ON -> pending saturates at 3. dropped pulses for one cycle per discarded event (2 pulses total). Exactly 4 blinks in total.
- Pulse on the last OFF cycle (pending=0) -> ON starts on the next edge with no IDLE cycle; pending stays 0.
- Queued pulse arriving in the same cycle a queued start decrements -> pending unchanged.
- RST_n low in the middle of ON with pending=2 -> out, busy and pending are 0 immediately, without waiting for an edge. A pulse after release blinks normally with 1-cycle latency.
